multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 75 +++++++
 rtl/multicycle_control_opcode_classify.sv | 38 +++
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared states, opcodes and datapath-select encodings
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ALU_A_RS1  = 2'b00;
  localparam logic [1:0] ALU_A_PC   = 2'b01;
  localparam logic [1:0] ALU_A_ZERO = 2'b10;

  localparam logic [1:0] ALU_B_RS2 = 2'b00;
  localparam logic [1:0] ALU_B_IMM = 2'b01;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt);
    logic taken;
    case (f3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_classify.sv
// rtl/multicycle_control_opcode_classify.sv - maps opcode/funct3 to an instruction class
module opcode_classify
  import multicycle_control_pkg::*;
#(
  parameter int unsigned SUPPORT_JUMP = 1
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  output op_class_t  op_class,
  output logic       illegal
);

  logic jump_ok;
  logic branch_f3_ok;

  assign jump_ok      = (SUPPORT_JUMP != 0);
  assign branch_f3_ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE) ||
                        (funct3 == F3_BLT) || (funct3 == F3_BGE);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op)
      OP_R:      op_class = CLS_R;
      OP_I:      op_class = CLS_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = branch_f3_ok ? CLS_BRANCH : CLS_ILLEGAL;
      OP_JAL:    op_class = jump_ok ? CLS_JAL   : CLS_ILLEGAL;
      OP_JALR:   op_class = jump_ok ? CLS_JALR  : CLS_ILLEGAL;
      OP_LUI:    op_class = jump_ok ? CLS_LUI   : CLS_ILLEGAL;
      OP_AUIPC:  op_class = jump_ok ? CLS_AUIPC : CLS_ILLEGAL;
      default:   op_class = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (op_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32 control FSM with memory-wait timeout and sticky trap
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned SUPPORT_JUMP = 1,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap,
  output logic [2:0] state
);

  localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  op_class_t        op_class;
  logic             illegal;
  logic             timeout;
  logic             taken;

  opcode_classify #(
    .SUPPORT_JUMP(SUPPORT_JUMP)
  ) u_classify (
    .op       (op),
    .funct3   (funct3),
    .op_class (op_class),
    .illegal  (illegal)
  );

  // Timeout fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
  assign timeout = !mem_ready && (wait_cnt == CNT_LAST);
  assign taken   = branch_taken(funct3, zero, lt);
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held so an in-flight access is dropped at once.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    reg_we    = 1'b0;
    imm_sel   = IMM_I;
    alu_src_a = ALU_A_RS1;
    alu_src_b = ALU_B_RS2;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    trap      = 1'b0;

    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_src  = PC_PLUS4;
            state_d = ST_DECODE;
          end else if (timeout) begin
            state_d = ST_TRAP;
          end
        end

        ST_DECODE: begin
          state_d = illegal ? ST_TRAP : ST_EXEC;
        end

        ST_EXEC: begin
          case (op_class)
            CLS_R: begin
              alu_src_a = ALU_A_RS1;
              alu_src_b = ALU_B_RS2;
              state_d   = ST_WB;
            end
            CLS_I: begin
              alu_src_b = ALU_B_IMM;
              imm_sel   = IMM_I;
              state_d   = ST_WB;
            end
            CLS_LOAD: begin
              alu_src_b = ALU_B_IMM;
              imm_sel   = IMM_I;
              state_d   = ST_MEM;
            end
            CLS_STORE: begin
              alu_src_b = ALU_B_IMM;
              imm_sel   = IMM_S;
              state_d   = ST_MEM;
            end
            CLS_BRANCH: begin
              imm_sel = IMM_B;
              pc_src  = PC_REL;
              pc_we   = taken;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CLS_JAL: begin
              imm_sel = IMM_J;
              pc_src  = PC_REL;
              pc_we   = 1'b1;
              reg_we  = 1'b1;
              wb_sel  = WB_PC;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CLS_JALR: begin
              imm_sel   = IMM_I;
              alu_src_b = ALU_B_IMM;
              pc_src    = PC_ALU;
              pc_we     = 1'b1;
              reg_we    = 1'b1;
              wb_sel    = WB_PC;
              retire    = 1'b1;
              state_d   = ST_FETCH;
            end
            CLS_LUI: begin
              alu_src_a = ALU_A_ZERO;
              alu_src_b = ALU_B_IMM;
              imm_sel   = IMM_U;
              state_d   = ST_WB;
            end
            CLS_AUIPC: begin
              alu_src_a = ALU_A_PC;
              alu_src_b = ALU_B_IMM;
              imm_sel   = IMM_U;
              state_d   = ST_WB;
            end
            default: state_d = ST_TRAP;
          endcase
        end

        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (op_class == CLS_STORE);
          if (mem_ready) begin
            if (op_class == CLS_STORE) begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (timeout) begin
            state_d = ST_TRAP;
          end
        end

        ST_WB: begin
          reg_we  = 1'b1;
          wb_sel  = (op_class == CLS_LOAD) ? WB_MEM : WB_ALU;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end

        ST_TRAP: begin
          trap = 1'b1;
        end

        default: state_d = ST_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - instruction-level reference model bench for multicycle_control
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq;
    logic       mwe;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcs;
    logic       rwe;
    logic [2:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] wb;
    logic       ret;
    logic       trp;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       mem_ready;

  logic       mem_req   [3];
  logic       mem_we    [3];
  logic       ir_we     [3];
  logic       pc_we     [3];
  logic [1:0] pc_src    [3];
  logic       reg_we    [3];
  logic [2:0] imm_sel   [3];
  logic [1:0] alu_src_a [3];
  logic [1:0] alu_src_b [3];
  logic [1:0] wb_sel    [3];
  logic       retire    [3];
  logic       trap      [3];
  logic [2:0] st        [3];
  logic [20:0] sig      [3];

  // Instance 0: defaults; 1: no jump support; 2: short memory timeout.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_control #(
      .SUPPORT_JUMP (g == 1 ? 0 : 1),
      .MEM_TIMEOUT  (g == 2 ? 3 : 15)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .funct3    (funct3),
      .zero      (zero),
      .lt        (lt),
      .mem_ready (mem_ready),
      .mem_req   (mem_req[g]),
      .mem_we    (mem_we[g]),
      .ir_we     (ir_we[g]),
      .pc_we     (pc_we[g]),
      .pc_src    (pc_src[g]),
      .reg_we    (reg_we[g]),
      .imm_sel   (imm_sel[g]),
      .alu_src_a (alu_src_a[g]),
      .alu_src_b (alu_src_b[g]),
      .wb_sel    (wb_sel[g]),
      .retire    (retire[g]),
      .trap      (trap[g]),
      .state     (st[g])
    );
    assign sig[g] = {st[g], mem_req[g], mem_we[g], ir_we[g], pc_we[g], pc_src[g], reg_we[g],
                     imm_sel[g], alu_src_a[g], alu_src_b[g], wb_sel[g], retire[g], trap[g]};
  end

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  ctl_t exp_q[$];
  bit   rdy_q[$];
  bit   ends_in_trap;

  function automatic ctl_t mk(input state_t s);
    ctl_t c;
    c     = '0;
    c.st  = s;
    c.trp = (s == ST_TRAP);
    return c;
  endfunction

  function automatic byte kind(input logic [6:0] o, input logic [2:0] f, input bit sj);
    case (o)
      7'b0110011: return "R";
      7'b0010011: return "I";
      7'b0000011: return "L";
      7'b0100011: return "S";
      7'b1100011: return (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) ? "B" : "X";
      7'b1101111: return sj ? "J" : "X";
      7'b1100111: return sj ? "j" : "X";
      7'b0110111: return sj ? "U" : "X";
      7'b0010111: return sj ? "A" : "X";
      default:    return "X";
    endcase
  endfunction

  task automatic push(input ctl_t c, input bit r);
    exp_q.push_back(c);
    rdy_q.push_back(r);
  endtask

  task automatic plan_wait(input ctl_t c, input int w, input int to, output bit tmo);
    tmo = 1'b0;
    for (int i = 0; i < w; i++) begin
      push(c, 1'b0);
      if (i + 1 == to) begin
        tmo = 1'b1;
        push(mk(ST_TRAP), 1'($urandom_range(0, 1)));
        return;
      end
    end
  endtask

  // Expected per-cycle control words for one whole instruction.
  task automatic plan(input logic [6:0] o, input logic [2:0] f, input logic z, input logic l,
                      input int fw, input int mw, input bit sj, input int to);
    ctl_t c;
    bit   tmo;
    byte  k;
    ends_in_trap = 1'b0;
    c = mk(ST_FETCH);
    c.mreq = 1'b1;
    plan_wait(c, fw, to, tmo);
    if (tmo) begin
      ends_in_trap = 1'b1;
      return;
    end
    c.irwe = 1'b1;
    c.pcwe = 1'b1;
    push(c, 1'b1);
    push(mk(ST_DECODE), 1'($urandom_range(0, 1)));
    k = kind(o, f, sj);
    if (k == "X") begin
      push(mk(ST_TRAP), 1'($urandom_range(0, 1)));
      ends_in_trap = 1'b1;
      return;
    end
    c = mk(ST_EXEC);
    case (k)
      "I", "L": begin c.b = 2'b01; c.imm = 3'b000; end
      "S":      begin c.b = 2'b01; c.imm = 3'b001; end
      "B": begin
        c.imm = 3'b010; c.pcs = 2'b01; c.ret = 1'b1;
        c.pcwe = (f == 3'd0 && z) || (f == 3'd1 && !z) || (f == 3'd4 && l) || (f == 3'd5 && !l);
      end
      "J": begin c.imm = 3'b100; c.pcs = 2'b01; c.pcwe = 1'b1; c.rwe = 1'b1; c.wb = 2'b10; c.ret = 1'b1; end
      "j": begin c.b = 2'b01; c.pcs = 2'b10; c.pcwe = 1'b1; c.rwe = 1'b1; c.wb = 2'b10; c.ret = 1'b1; end
      "U": begin c.a = 2'b10; c.b = 2'b01; c.imm = 3'b011; end
      "A": begin c.a = 2'b01; c.b = 2'b01; c.imm = 3'b011; end
      default: ;
    endcase
    push(c, 1'($urandom_range(0, 1)));
    if (k == "B" || k == "J" || k == "j") return;
    if (k == "L" || k == "S") begin
      c = mk(ST_MEM);
      c.mreq = 1'b1;
      c.mwe  = (k == "S");
      plan_wait(c, mw, to, tmo);
      if (tmo) begin
        ends_in_trap = 1'b1;
        return;
      end
      c.ret = (k == "S");
      push(c, 1'b1);
      if (k == "S") return;
    end
    c = mk(ST_WB);
    c.rwe = 1'b1;
    c.wb  = (k == "L") ? 2'b01 : 2'b00;
    c.ret = 1'b1;
    push(c, 1'($urandom_range(0, 1)));
  endtask

  task automatic check(input ctl_t obs, input ctl_t exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_n(input int sel, input string tag, input int n);
    int idx = 0;
    while (exp_q.size() > 0 && idx < n) begin
      ctl_t e;
      e = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      check(sig[sel], e, $sformatf("%s[%0d]", tag, idx));
      @(posedge clk);
      #1;
      idx++;
    end
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic z, input logic l);
    op = o; funct3 = f; zero = z; lt = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check(sig[i], mk(ST_FETCH), $sformatf("reset%0d", i));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [2:0] brf [4];
    logic [6:0] o;
    logic [2:0] f;
    int         fw, mw;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    brf = '{3'd0, 3'd1, 3'd4, 3'd5};
    rst_n = 1'b0;
    mem_ready = 1'b0;
    set_instr(7'b0110011, 3'd0, 1'b0, 1'b0);
    do_reset();

    plan(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, 1'b1, 15);
    run_n(0, "add", 1000);

    set_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    plan(op, funct3, zero, lt, 0, 3, 1'b1, 15);
    run_n(0, "lw_wait3", 1000);

    set_instr(7'b1100011, 3'd1, 1'b0, 1'b0);
    plan(op, funct3, zero, lt, 0, 0, 1'b1, 15);
    run_n(0, "bne_taken", 1000);
    set_instr(7'b1100011, 3'd1, 1'b1, 1'b0);
    plan(op, funct3, zero, lt, 0, 0, 1'b1, 15);
    run_n(0, "bne_not_taken", 1000);

    do_reset();
    set_instr(7'b1101111, 3'd0, 1'b0, 1'b0);
    plan(op, funct3, zero, lt, 0, 0, 1'b0, 15);
    for (int i = 0; i < 20; i++) push(mk(ST_TRAP), 1'($urandom_range(0, 1)));
    run_n(1, "jal_nojump_trap", 1000);
    do_reset();

    set_instr(7'b0110011, 3'd0, 1'b0, 1'b0);
    plan(op, funct3, zero, lt, 10, 0, 1'b1, 3);
    run_n(2, "fetch_timeout", 1000);
    do_reset();
    plan(op, funct3, zero, lt, 2, 0, 1'b1, 3);
    run_n(2, "fetch_ready_3rd", 1000);
    set_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    plan(op, funct3, zero, lt, 0, 6, 1'b1, 3);
    run_n(2, "mem_timeout", 1000);

    do_reset();
    set_instr(7'b0100011, 3'd2, 1'b0, 1'b0);
    plan(op, funct3, zero, lt, 0, 10, 1'b1, 15);
    run_n(0, "sw_pre_reset", 5);
    rst_n = 1'b0;
    #1;
    check(sig[0], mk(ST_FETCH), "sw_reset_in_mem");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    begin
      ctl_t c;
      c = mk(ST_FETCH);
      c.mreq = 1'b1;
      check(sig[0], c, "refetch_after_reset");
    end
    @(posedge clk);
    #1;

    do_reset();
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) o = 7'($urandom);
      f = 3'($urandom);
      if (o == 7'b1100011 && $urandom_range(0, 3) != 0) f = brf[$urandom_range(0, 3)];
      fw = $urandom_range(0, 4);
      mw = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) mw = 14;
      if ($urandom_range(0, 19) == 0) fw = 20;
      set_instr(o, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      plan(op, funct3, zero, lt, fw, mw, 1'b1, 15);
      run_n(0, $sformatf("rnd%0d_op%b_f%0d", n, o, f), 1000);
      if (ends_in_trap) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
